// File: rtl/riscv_dmem_responder_pkg.sv
// ---------------------------------------------------------------------------
// riscv_dmem_pkg
// Shared definitions for the RISC-V data-memory responder:
//   state_t       - responder FSM states (IDLE / WAIT / RESP)
//   BE_*          - the byte-enable patterns a core legitimately issues
//   be_legal()    - true when a byte-enable pattern is naturally aligned to
//                   the low address bits (used only when the alignment check
//                   is compiled in with DMEM_MISALIGN_CHECK_EN)
// ---------------------------------------------------------------------------
package riscv_dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_BYTE1   = 4'b0010;
    localparam logic [3:0] BE_BYTE2   = 4'b0100;
    localparam logic [3:0] BE_BYTE3   = 4'b1000;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    // Single bytes may sit anywhere, halves must match addr[1], words must be
    // word aligned; every other pattern (including 0000) is illegal.
    function automatic logic be_legal(input logic [3:0] i_be, input logic [1:0] i_lo);
        case (i_be)
            BE_BYTE0, BE_BYTE1, BE_BYTE2, BE_BYTE3: return 1'b1;
            BE_HALF_LO: return ~i_lo[1];
            BE_HALF_HI: return i_lo[1];
            BE_WORD:    return (i_lo == 2'b00);
            default:    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/riscv_dmem_responder_if.sv
// ---------------------------------------------------------------------------
// riscv_dmem_responder_if
// Core-to-data-memory bus.
//   i_addr, i_write_data, i_byteen, i_write_en, i_read_en : request (core)
//   o_read_data, o_read_valid, o_ready, o_fault           : response (memory)
// Modports: master (core side), slave (memory side).
// ---------------------------------------------------------------------------
interface riscv_dmem_responder_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] i_addr;
    logic [WIDTH-1:0] i_write_data;
    logic [3:0]       i_byteen;
    logic             i_write_en;
    logic             i_read_en;
    logic [WIDTH-1:0] o_read_data;
    logic             o_read_valid;
    logic             o_ready;
    logic             o_fault;

    modport master (
        output i_addr, i_write_data, i_byteen, i_write_en, i_read_en,
        input  o_read_data, o_read_valid, o_ready, o_fault
    );

    modport slave (
        input  i_addr, i_write_data, i_byteen, i_write_en, i_read_en,
        output o_read_data, o_read_valid, o_ready, o_fault
    );
endinterface

// File: rtl/riscv_dmem_responder_sram_bank.sv
// ---------------------------------------------------------------------------
// dmem_sram_bank
// DEPTH_WORDS x 4 byte-lane single-port RAM with per-lane write enables and
// a registered read port. Contents and read register are not reset.
//   i_clk          clock
//   i_write_en     commit i_write_data lanes selected by i_byteen
//   i_read_en      capture addressed word into o_read_data
//   i_index        word index
//   i_write_data   lane-aligned store data
//   i_byteen       byte-lane enables
//   o_read_data    registered read word (changes only on i_read_en)
// ---------------------------------------------------------------------------
module dmem_sram_bank #(
    parameter int WIDTH       = 32,
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                           i_clk,
    input  logic                           i_write_en,
    input  logic                           i_read_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] i_index,
    input  logic [WIDTH-1:0]               i_write_data,
    input  logic [3:0]                     i_byteen,
    output logic [WIDTH-1:0]               o_read_data
);
    localparam int LANE = WIDTH / 4;

    logic [WIDTH-1:0] r_mem [DEPTH_WORDS];
    logic [WIDTH-1:0] r_read_data;

    always_ff @(posedge i_clk) begin
        if (i_write_en) begin
            for (int k = 0; k < 4; k++) begin
                if (i_byteen[k]) begin
                    r_mem[i_index][k*LANE +: LANE] <= i_write_data[k*LANE +: LANE];
                end
            end
        end
        if (i_read_en) begin
            r_read_data <= r_mem[i_index];
        end
    end

    assign o_read_data = r_read_data;

endmodule

// File: rtl/riscv_dmem_responder.sv
// ---------------------------------------------------------------------------
// riscv_dmem_responder
// Data-memory responder for a RISC-V core: accepts one load/store per IDLE
// cycle, optionally stretches it by WAIT_STATES busy cycles, flags accesses
// that are out of range or carry both read and write enables.
//   i_clk       clock (rising edge)
//   i_reset_n   asynchronous active-low reset
//   bus         riscv_dmem_responder_if.slave (request in, response out)
// Optional feature: define DMEM_MISALIGN_CHECK_EN to fault byte enables that
// are not naturally aligned to the address (write suppressed, read gives 0).
// ---------------------------------------------------------------------------
module riscv_dmem_responder
    import riscv_dmem_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 0
) (
    input logic                   i_clk,
    input logic                   i_reset_n,
    riscv_dmem_responder_if.slave bus
);
    localparam int               IDX_BITS = $clog2(DEPTH_WORDS);
    localparam logic [WIDTH-1:0] LIMIT    = WIDTH'(4 * DEPTH_WORDS);

    state_t           r_state, w_next_state;
    logic [3:0]       r_count;
    logic [WIDTH-1:0] r_addr, r_wdata;
    logic [3:0]       r_byteen;
    logic             r_we, r_re;
    logic             r_read_valid, r_fault, r_data_zero;

    logic             w_idle, w_req, w_issue;
    logic [WIDTH-1:0] w_addr, w_wdata, w_sram_rdata;
    logic [3:0]       w_byteen;
    logic             w_we, w_re, w_oor, w_misalign, w_bad;
    logic             w_sram_we, w_sram_re;

    // Zero wait states operate straight off the bus; otherwise the access
    // executes later from the copy latched on the accepting edge.
    assign w_idle   = (r_state == IDLE);
    assign w_req    = w_idle & (bus.i_read_en | bus.i_write_en);
    assign w_addr   = w_idle ? bus.i_addr       : r_addr;
    assign w_wdata  = w_idle ? bus.i_write_data : r_wdata;
    assign w_byteen = w_idle ? bus.i_byteen     : r_byteen;
    assign w_we     = w_idle ? bus.i_write_en   : r_we;
    assign w_re     = w_idle ? bus.i_read_en    : r_re;

    // Gated by reset so a request held on the bus during reset cannot
    // touch the (unreset) memory array.
    assign w_issue = i_reset_n & ((WAIT_STATES == 0) ? w_req
                                  : (r_state == WAIT && r_count == 4'd0));

    assign w_oor = (w_addr >= LIMIT);
`ifdef DMEM_MISALIGN_CHECK_EN
    assign w_misalign = ~be_legal(w_byteen, w_addr[1:0]);
`else
    assign w_misalign = 1'b0;
`endif
    assign w_bad = w_oor | w_misalign;

    // Read+write together behaves as a write.
    assign w_sram_we = w_issue & w_we & ~w_bad;
    assign w_sram_re = w_issue & w_re & ~w_we & ~w_bad;

    dmem_sram_bank #(
        .WIDTH       (WIDTH),
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_bank (
        .i_clk        (i_clk),
        .i_write_en   (w_sram_we),
        .i_read_en    (w_sram_re),
        .i_index      (w_addr[IDX_BITS+1:2]),
        .i_write_data (w_wdata),
        .i_byteen     (w_byteen),
        .o_read_data  (w_sram_rdata)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_req && WAIT_STATES != 0) w_next_state = WAIT;
            WAIT:    if (r_count == 4'd0) w_next_state = RESP;
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // r_data_zero masks the RAM read register so faulted reads (and the
    // post-reset value) show zero without an extra cycle of read latency.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_count      <= 4'd0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_byteen     <= 4'd0;
            r_we         <= 1'b0;
            r_re         <= 1'b0;
            r_read_valid <= 1'b0;
            r_fault      <= 1'b0;
            r_data_zero  <= 1'b1;
        end else begin
            if (w_req && WAIT_STATES != 0) begin
                r_addr   <= bus.i_addr;
                r_wdata  <= bus.i_write_data;
                r_byteen <= bus.i_byteen;
                r_we     <= bus.i_write_en;
                r_re     <= bus.i_read_en;
                r_count  <= 4'(WAIT_STATES - 1);
            end else if (r_state == WAIT && r_count != 4'd0) begin
                r_count <= r_count - 4'd1;
            end
            r_read_valid <= w_issue & w_re & ~w_we;
            r_fault      <= w_issue & (w_bad | (w_re & w_we));
            if (w_issue && w_re && !w_we) begin
                r_data_zero <= w_bad;
            end
        end
    end

    assign bus.o_ready      = w_idle;
    assign bus.o_read_valid = r_read_valid;
    assign bus.o_fault      = r_fault;
    assign bus.o_read_data  = r_data_zero ? '0 : w_sram_rdata;

endmodule

// File: doc/riscv_dmem_responder.md
RISCV_DMEM_RESPONDER -- requirements
Module: riscv_dmem_responder

Interface
REQ-001 Parameter WIDTH, 32, data/address width in bits.
REQ-002 Parameter DEPTH_WORDS, 1024, number of WIDTH-bit words; power of two.
REQ-003 Parameter WAIT_STATES, 0, extra busy cycles per access (0..15).
REQ-004 Port i_clk  input  1  sole clock, rising edge.
REQ-005 Port i_reset_n  input  1  asynchronous, active-low reset.
REQ-006 Port i_addr  input  WIDTH  byte address from core.
REQ-007 Port i_write_data  input  WIDTH  store data, already lane-aligned by core.
REQ-008 Port i_byteen  input  4  byte-lane enables.
REQ-009 Port i_write_en  input  1  store request.
REQ-010 Port i_read_en  input  1  load request.
REQ-011 Port o_read_data  output  WIDTH  full word read, registered.
REQ-012 Port o_read_valid  output  1  one-cycle pulse, o_read_data valid.
REQ-013 Port o_ready  output  1  high when a new request is accepted this cycle.
REQ-014 Port o_fault  output  1  one-cycle pulse on rejected access.

Function
REQ-015 States IDLE, WAIT, RESP; o_ready = (state == IDLE).
REQ-016 Request = i_read_en | i_write_en sampled only in IDLE; inputs ignored in WAIT/RESP.
REQ-017 Word index = i_addr[log2(DEPTH_WORDS)+1:2]; out-of-range when i_addr >= 4*DEPTH_WORDS.
REQ-018 WAIT_STATES=0: write commits on accepting edge; read data and o_read_valid appear the cycle after acceptance; FSM stays IDLE, full throughput.
REQ-019 WAIT_STATES=N>0: accepting edge latches address/data/byteen/op, IDLE->WAIT; counter loads N-1, decrements; at 0 WAIT->RESP; RESP commits write or drives read data + o_read_valid, RESP->IDLE; o_ready low N+1 cycles.
REQ-020 Write updates only lanes with i_byteen[k]=1; other bytes unchanged.
REQ-021 Read returns the whole addressed word regardless of i_byteen.
REQ-022 Read of a word written by the immediately preceding accepted access returns the new data.
REQ-023 i_read_en and i_write_en both high: executes as write, no o_read_valid, o_fault pulses.
REQ-024 Out-of-range: write dropped, read returns 0 with o_read_valid, o_fault pulses.
REQ-025 o_fault and o_read_valid pulse in the same cycle the access completes.
REQ-026 o_read_data holds its last value when o_read_valid is low.

Reset
REQ-027 i_reset_n low: state IDLE, counter 0, o_read_data 0, o_read_valid 0, o_fault 0, latched request cleared; o_ready 1.
REQ-028 Reset mid-WAIT aborts the access; pending write does not commit.
REQ-029 Memory array is not reset; contents undefined after power-up.

Configuration
REQ-030 Macro DMEM_MISALIGN_CHECK_EN defined: legal i_byteen is 0001/0010/0100/1000 (any addr), 0011 (addr[1]=0), 1100 (addr[1]=1), 1111 (addr[1:0]=0); others, or 0000 with a request, fault (write suppressed, read returns 0).
REQ-031 Macro undefined: no alignment check; any i_byteen accepted, o_fault only from REQ-023/REQ-024.

Structure
REQ-032 Package riscv_dmem_pkg holds the state enum (IDLE/WAIT/RESP) and byteen constants (BE_BYTE0..3, BE_HALF_LO, BE_HALF_HI, BE_WORD).
REQ-033 Sub-module dmem_sram_bank: DEPTH_WORDS x 4 byte lanes, per-lane write enable, registered read port; FSM, range and alignment checks stay in riscv_dmem_responder.

Verification
REQ-034 WAIT_STATES=0: write 0xDEADBEEF byteen 1111 @0x10, next cycle read @0x10 -> o_read_valid next cycle, data 0xDEADBEEF.
REQ-035 Preload 0x11223344 @0x20, write 0x0000AA00 byteen 0010 -> read returns 0x1122AA44.
REQ-036 WAIT_STATES=3: read @0x0 -> o_ready low 4 cycles, o_read_valid on 4th cycle after acceptance; requests during WAIT ignored.
REQ-037 Read @4*DEPTH_WORDS -> o_read_data 0, o_read_valid=1, o_fault=1; write there leaves all words unchanged.
REQ-038 DMEM_MISALIGN_CHECK_EN: write byteen 1111 @0x22 -> o_fault=1, word @0x20 unchanged; without macro write commits.
REQ-039 WAIT_STATES=2: write accepted, i_reset_n low in WAIT -> outputs reset, target word unchanged.
